// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared constants and dispatcher state encodings
package miner_pkg;

  localparam int NONCE_W = 32;

  typedef enum logic [2:0] {
    DISPATCH_IDLE = 3'd0,
    DISPATCH_CALC = 3'd1,
    DISPATCH_LOAD = 3'd2,
    DISPATCH_RUN  = 3'd3,
    DISPATCH_DONE = 3'd4
  } dispatch_state_t;

endpackage

// File: rtl/golden_fifo.sv
// rtl/golden_fifo.sv - synchronous golden-nonce FIFO with flush and full/empty flags
module golden_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_pop;
  logic                  do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  // A pop on a full FIFO frees the slot the concurrent push lands in.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero when empty so stale storage never leaks out.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; flush discards everything at once.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/miner_dispatch.sv
// rtl/miner_dispatch.sv - splits a nonce range across hash cores and gathers golden nonces
module miner_dispatch
  import miner_pkg::*;
#(
  parameter int CORES_LOG2 = 2,
  parameter int FIFO_LOG2  = 3,
  parameter int DROP_W     = 8,
  localparam int NUM_CORES = 2 ** CORES_LOG2
) (
  input  logic                           hash_clk,
  input  logic                           reset,
  input  logic                           new_work,
  input  logic [NONCE_W-1:0]             nonce_min,
  input  logic [NONCE_W-1:0]             nonce_max,
  output logic [NUM_CORES-1:0]           core_reset,
  output logic [NONCE_W*NUM_CORES-1:0]   core_nonce_min,
  output logic [NONCE_W*NUM_CORES-1:0]   core_nonce_max,
  output logic [NUM_CORES-1:0]           core_enable,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES-1:0]           core_golden_valid,
  input  logic [NONCE_W*NUM_CORES-1:0]   core_golden_nonce,
  output logic                           golden_valid,
  input  logic                           golden_ready,
  output logic [NONCE_W-1:0]             golden_nonce,
  output logic                           job_busy,
  output logic                           job_done,
  output logic [DROP_W-1:0]              drop_count
);

  localparam int IDX_W = (CORES_LOG2 > 0) ? CORES_LOG2 : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

  dispatch_state_t state;
  logic [NONCE_W-1:0] job_min;
  logic [NONCE_W-1:0] job_max;
  logic [NONCE_W:0]   span;
  logic [NONCE_W:0]   chunk;
  logic [1:0]         guard;

  logic [NONCE_W*NUM_CORES-1:0] slice_min;
  logic [NONCE_W*NUM_CORES-1:0] slice_max;
  logic [NUM_CORES-1:0]         slice_en;
  logic [NONCE_W-1:0]           lo;

  logic [NUM_CORES-1:0] pend;
  logic [NONCE_W-1:0]   hold [NUM_CORES];
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     cand;
  logic                 grant_any;
  logic [NUM_CORES-1:0] granted;
  logic [NUM_CORES-1:0] accept;
  logic [NUM_CORES-1:0] dropped;
  logic [4:0]           drop_n;
  logic [DROP_W+4:0]    drop_sum;
  logic                 capture_ok;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 push;

  // 33-bit span so the full 2^32 range does not wrap to zero.
  assign span = {1'b0, job_max} - {1'b0, job_min} + {{NONCE_W{1'b0}}, 1'b1};

  // Slice layout from the latched job and the chunk computed in CALC.
  always_comb begin
    slice_min = '0;
    slice_max = '0;
    slice_en  = '0;
    lo        = '0;
    if (chunk == '0) begin
      slice_min[NONCE_W-1:0] = job_min;
      slice_max[NONCE_W-1:0] = job_max;
      slice_en[0]            = 1'b1;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        lo = job_min + chunk[NONCE_W-1:0] * NONCE_W'(i);
        slice_min[NONCE_W*i +: NONCE_W] = lo;
        slice_max[NONCE_W*i +: NONCE_W] = lo + chunk[NONCE_W-1:0] - 1'b1;
      end
      slice_max[NONCE_W*(NUM_CORES-1) +: NONCE_W] = job_max;
      slice_en = '1;
    end
  end

  // Job sequencing FSM; new_work restarts from any state.
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state          <= DISPATCH_IDLE;
      job_min        <= '0;
      job_max        <= '0;
      chunk          <= '0;
      guard          <= '0;
      core_reset     <= '0;
      core_enable    <= '0;
      core_nonce_min <= '0;
      core_nonce_max <= '0;
      job_busy       <= 1'b0;
      job_done       <= 1'b0;
    end else begin
      core_reset <= '0;
      if (new_work) begin
        job_min     <= nonce_min;
        job_max     <= nonce_max;
        core_enable <= '0;
        job_busy    <= 1'b1;
        job_done    <= 1'b0;
        state       <= DISPATCH_CALC;
      end else begin
        case (state)
          DISPATCH_CALC: begin
            chunk <= span >> CORES_LOG2;
            state <= DISPATCH_LOAD;
          end
          DISPATCH_LOAD: begin
            core_nonce_min <= slice_min;
            core_nonce_max <= slice_max;
            core_enable    <= slice_en;
            core_reset     <= slice_en;
            // Skip the core_reset cycle plus two more while cores drop stale done.
            guard          <= 2'd3;
            state          <= DISPATCH_RUN;
          end
          DISPATCH_RUN: begin
            if (guard != 2'd0) begin
              guard <= guard - 2'd1;
            end else if (&(core_done | ~core_enable)) begin
              job_busy <= 1'b0;
              job_done <= 1'b1;
              state    <= DISPATCH_DONE;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

  assign capture_ok = ((state == DISPATCH_RUN) || (state == DISPATCH_DONE)) && !new_work;
  assign pop        = golden_ready && !fifo_empty;
  assign push       = grant_any && (!fifo_full || pop);

  // Round-robin pick: nearest pending core after the last one granted.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_CORES; k >= 1; k--) begin
      cand = last_grant + IDX_W'(k);
      if (NUM_CORES == 1) cand = '0;
      if (pend[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Per-core capture qualification and overflow detection.
  always_comb begin
    granted = '0;
    accept  = '0;
    dropped = '0;
    drop_n  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      granted[i] = push && (grant_idx == IDX_W'(i));
      accept[i]  = core_golden_valid[i] && core_enable[i] && capture_ok;
      dropped[i] = accept[i] && pend[i] && !granted[i];
      drop_n     = drop_n + {4'b0, dropped[i]};
    end
    drop_sum = {5'b0, drop_count} + {{DROP_W{1'b0}}, drop_n};
  end

  // Holding registers, pending bits, arbiter pointer and drop counter.
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      pend       <= '0;
      last_grant <= LAST_IDX;
      drop_count <= '0;
      for (int i = 0; i < NUM_CORES; i++) hold[i] <= '0;
    end else begin
      if (drop_n != 5'd0) begin
        drop_count <= (|drop_sum[DROP_W+4:DROP_W]) ? '1 : drop_sum[DROP_W-1:0];
      end
      if (new_work) begin
        pend       <= '0;
        last_grant <= LAST_IDX;
      end else begin
        if (push) last_grant <= grant_idx;
        for (int i = 0; i < NUM_CORES; i++) begin
          if (accept[i]) begin
            if (!pend[i] || granted[i]) begin
              hold[i] <= core_golden_nonce[NONCE_W*i +: NONCE_W];
              pend[i] <= 1'b1;
            end
          end else if (granted[i]) begin
            pend[i] <= 1'b0;
          end
        end
      end
    end
  end

  golden_fifo #(
    .WIDTH      (NONCE_W),
    .DEPTH_LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk       (hash_clk),
    .reset     (reset),
    .flush     (new_work),
    .push      (push),
    .push_data (hold[grant_idx]),
    .pop       (pop),
    .rd_data   (golden_nonce),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign golden_valid = !fifo_empty;

endmodule

// File: tb/tb_miner_dispatch.sv
// tb/tb_miner_dispatch.sv - directed self-checking bench for miner_dispatch
module tb_miner_dispatch;

  logic          hash_clk;
  logic          reset;
  logic          new_work;
  logic [31:0]   nonce_min;
  logic [31:0]   nonce_max;
  logic [3:0]    core_reset;
  logic [127:0]  core_nonce_min;
  logic [127:0]  core_nonce_max;
  logic [3:0]    core_enable;
  logic [3:0]    core_done;
  logic [3:0]    core_golden_valid;
  logic [127:0]  core_golden_nonce;
  logic          golden_valid;
  logic          golden_ready;
  logic [31:0]   golden_nonce;
  logic          job_busy;
  logic          job_done;
  logic [7:0]    drop_count;

  int total;
  int bad;

  miner_dispatch #(.CORES_LOG2(2), .FIFO_LOG2(3), .DROP_W(8)) dut (
    .hash_clk          (hash_clk),
    .reset             (reset),
    .new_work          (new_work),
    .nonce_min         (nonce_min),
    .nonce_max         (nonce_max),
    .core_reset        (core_reset),
    .core_nonce_min    (core_nonce_min),
    .core_nonce_max    (core_nonce_max),
    .core_enable       (core_enable),
    .core_done         (core_done),
    .core_golden_valid (core_golden_valid),
    .core_golden_nonce (core_golden_nonce),
    .golden_valid      (golden_valid),
    .golden_ready      (golden_ready),
    .golden_nonce      (golden_nonce),
    .job_busy          (job_busy),
    .job_done          (job_done),
    .drop_count        (drop_count)
  );

  initial begin
    hash_clk = 1'b0;
    forever #5 hash_clk = ~hash_clk;
  end

  task automatic tick();
    @(posedge hash_clk);
    #1;
  endtask

  // Pulse new_work and advance to the cycle where slices are visible (t+2).
  task automatic start_job(input logic [31:0] lo, input logic [31:0] hi);
    nonce_min = lo;
    nonce_max = hi;
    new_work  = 1'b1;
    tick();
    new_work  = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (golden_valid !== 1'b0) begin bad++; $display("FAIL reset_golden_valid got=%b want=0", golden_valid); end
    total++; if (core_enable !== 4'b0) begin bad++; $display("FAIL reset_core_enable got=%b want=0000", core_enable); end
    total++; if ({job_busy, job_done} !== 2'b00) begin bad++; $display("FAIL reset_job_flags got=%b want=00", {job_busy, job_done}); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL reset_drop_count got=%0d want=0", drop_count); end
    total++; if (core_nonce_min !== 128'd0 || core_nonce_max !== 128'd0 || golden_nonce !== 32'd0) begin bad++; $display("FAIL reset_data got=%h/%h/%h want=0", core_nonce_min, core_nonce_max, golden_nonce); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_partition();
    logic [31:0] exp_lo [4];
    logic [31:0] exp_hi [4];
    exp_lo = '{32'h1000, 32'h1100, 32'h1200, 32'h1300};
    exp_hi = '{32'h10FF, 32'h11FF, 32'h12FF, 32'h13FF};
    start_job(32'h1000, 32'h13FF);
    total++; if (core_reset !== 4'b1111) begin bad++; $display("FAIL part_core_reset got=%b want=1111", core_reset); end
    total++; if (core_enable !== 4'b1111) begin bad++; $display("FAIL part_core_enable got=%b want=1111", core_enable); end
    total++; if (job_busy !== 1'b1) begin bad++; $display("FAIL part_job_busy got=%b want=1", job_busy); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (core_nonce_min[32*i +: 32] !== exp_lo[i] || core_nonce_max[32*i +: 32] !== exp_hi[i]) begin
        bad++;
        $display("FAIL part_slice%0d got=%h-%h want=%h-%h", i, core_nonce_min[32*i +: 32], core_nonce_max[32*i +: 32], exp_lo[i], exp_hi[i]);
      end
    end
    tick();
    total++; if (core_reset !== 4'b0000) begin bad++; $display("FAIL part_reset_pulse got=%b want=0000", core_reset); end
  endtask

  task automatic test_small_job_done();
    start_job(32'h10, 32'h12);
    total++; if (core_enable !== 4'b0001 || core_reset !== 4'b0001) begin bad++; $display("FAIL small_enable got=%b/%b want=0001/0001", core_enable, core_reset); end
    total++; if (core_nonce_min[31:0] !== 32'h10 || core_nonce_max[31:0] !== 32'h12) begin bad++; $display("FAIL small_slice0 got=%h-%h want=10-12", core_nonce_min[31:0], core_nonce_max[31:0]); end
    total++; if (core_nonce_min[127:32] !== 96'd0 || core_nonce_max[127:32] !== 96'd0) begin bad++; $display("FAIL small_disabled_slices got=%h/%h want=0", core_nonce_min[127:32], core_nonce_max[127:32]); end
    for (int i = 0; i < 4; i++) tick();
    total++; if (job_done !== 1'b0 || job_busy !== 1'b1) begin bad++; $display("FAIL small_running got=done%b busy%b want=done0 busy1", job_done, job_busy); end
    core_done = 4'b0001;
    tick();
    tick();
    total++; if (job_done !== 1'b1 || job_busy !== 1'b0) begin bad++; $display("FAIL small_done got=done%b busy%b want=done1 busy0", job_done, job_busy); end
    core_done = 4'b0000;
  endtask

  task automatic test_full_range();
    start_job(32'h0, 32'hFFFF_FFFF);
    total++; if (core_enable !== 4'b1111) begin bad++; $display("FAIL full_enable got=%b want=1111", core_enable); end
    total++; if (core_nonce_max[31:0] !== 32'h3FFF_FFFF || core_nonce_min[63:32] !== 32'h4000_0000) begin bad++; $display("FAIL full_chunk got=%h/%h want=3fffffff/40000000", core_nonce_max[31:0], core_nonce_min[63:32]); end
    total++; if (core_nonce_min[127:96] !== 32'hC000_0000 || core_nonce_max[127:96] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL full_core3 got=%h-%h want=c0000000-ffffffff", core_nonce_min[127:96], core_nonce_max[127:96]); end
  endtask

  task automatic test_remainder();
    start_job(32'h0, 32'h0A);
    total++; if (core_nonce_min[127:96] !== 32'h6 || core_nonce_max[127:96] !== 32'hA) begin bad++; $display("FAIL rem_core3 got=%h-%h want=6-a", core_nonce_min[127:96], core_nonce_max[127:96]); end
    total++; if (core_nonce_min[95:64] !== 32'h4 || core_nonce_max[95:64] !== 32'h5 || core_nonce_max[31:0] !== 32'h1) begin bad++; $display("FAIL rem_core2 got=%h-%h c0max=%h want=4-5 c0max=1", core_nonce_min[95:64], core_nonce_max[95:64], core_nonce_max[31:0]); end
  endtask

  task automatic test_order();
    start_job(32'h1000, 32'h13FF);
    golden_ready = 1'b1;
    core_golden_valid = 4'b1111;
    for (int i = 0; i < 4; i++) core_golden_nonce[32*i +: 32] = 32'hA0 + 32'(i);
    tick();
    core_golden_valid = 4'b0000;
    total++; if (golden_valid !== 1'b0) begin bad++; $display("FAIL order_latency got=%b want=0", golden_valid); end
    tick();
    for (int j = 0; j < 4; j++) begin
      total++;
      if (golden_valid !== 1'b1 || golden_nonce !== 32'hA0 + 32'(j)) begin
        bad++;
        $display("FAIL order_item%0d got=v%b %h want=v1 %h", j, golden_valid, golden_nonce, 32'hA0 + 32'(j));
      end
      tick();
    end
    total++; if (golden_valid !== 1'b0 || drop_count !== 8'd0) begin bad++; $display("FAIL order_end got=v%b drops=%0d want=v0 drops=0", golden_valid, drop_count); end
  endtask

  task automatic test_overflow();
    start_job(32'h1000, 32'h13FF);
    golden_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      core_golden_valid = 4'b0010;
      core_golden_nonce[63:32] = 32'hB0 + 32'(k);
      tick();
    end
    core_golden_valid = 4'b0000;
    tick();
    total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL ovf_drop_count got=%0d want=1", drop_count); end
    total++; if (golden_valid !== 1'b1 || golden_nonce !== 32'hB0) begin bad++; $display("FAIL ovf_head got=v%b %h want=v1 b0", golden_valid, golden_nonce); end
    golden_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      total++;
      if (golden_valid !== 1'b1 || golden_nonce !== 32'hB0 + 32'(j)) begin
        bad++;
        $display("FAIL ovf_item%0d got=v%b %h want=v1 %h", j, golden_valid, golden_nonce, 32'hB0 + 32'(j));
      end
      tick();
    end
    total++; if (golden_valid !== 1'b0 || drop_count !== 8'd1) begin bad++; $display("FAIL ovf_drain_end got=v%b drops=%0d want=v0 drops=1", golden_valid, drop_count); end
  endtask

  task automatic test_midrun_restart();
    start_job(32'h2000, 32'h23FF);
    golden_ready = 1'b0;
    core_golden_valid = 4'b0111;
    for (int i = 0; i < 4; i++) core_golden_nonce[32*i +: 32] = 32'hC0 + 32'(i);
    tick();
    core_golden_valid = 4'b0000;
    tick();
    tick();
    tick();
    total++; if (golden_valid !== 1'b1 || golden_nonce !== 32'hC0) begin bad++; $display("FAIL mid_fifo_loaded got=v%b %h want=v1 c0", golden_valid, golden_nonce); end
    nonce_min = 32'h5000;
    nonce_max = 32'h53FF;
    new_work  = 1'b1;
    tick();
    new_work  = 1'b0;
    total++; if (golden_valid !== 1'b0 || job_done !== 1'b0 || job_busy !== 1'b1) begin bad++; $display("FAIL mid_flush got=v%b done%b busy%b want=v0 done0 busy1", golden_valid, job_done, job_busy); end
    total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL mid_drop_kept got=%0d want=1", drop_count); end
    tick();
    tick();
    total++; if (core_reset !== 4'b1111 || core_nonce_min[31:0] !== 32'h5000 || core_nonce_max[127:96] !== 32'h53FF) begin bad++; $display("FAIL mid_reload got=%b %h %h want=1111 5000 53ff", core_reset, core_nonce_min[31:0], core_nonce_max[127:96]); end
    tick();
    total++; if (golden_valid !== 1'b0) begin bad++; $display("FAIL mid_no_stale got=%b want=0", golden_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if ({core_enable, core_reset, job_busy, job_done, golden_valid} !== 11'd0 || drop_count !== 8'd0 || core_nonce_min !== 128'd0) begin bad++; $display("FAIL mid_reset got=%b %b %b%b%b drops=%0d want=all zero", core_enable, core_reset, job_busy, job_done, golden_valid, drop_count); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    new_work = 1'b0;
    nonce_min = '0;
    nonce_max = '0;
    core_done = '0;
    core_golden_valid = '0;
    core_golden_nonce = '0;
    golden_ready = 1'b0;
    test_reset();
    test_partition();
    test_small_job_done();
    test_full_range();
    test_remainder();
    test_order();
    test_overflow();
    test_midrun_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/miner_dispatch.md
Name: miner_dispatch

Overview:
- Parametrised successor to the single-core miner top. Fans one job out across NUM_CORES hash cores by splitting the job's nonce range into equal contiguous slices.
- Collects golden nonces from all cores through per-core holding registers, a round-robin arbiter and an output FIFO. The comm block drains that FIFO with a valid/ready handshake.
- Sits between uart_comm and an array of fpgaminer_top cores, entirely in the hash_clk domain (CDC stays in uart_comm).

Parameters:
- CORES_LOG2, 2, log2 of core count; NUM_CORES = 2**CORES_LOG2 (1..16 cores).
- FIFO_LOG2, 3, log2 of golden-nonce FIFO depth (depth 8).
- DROP_W, 8, width of saturating dropped-nonce counter.

Ports:
- hash_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high; clears all state.
- new_work  in  1  one-cycle pulse; latch nonce_min/nonce_max and start a job.
- nonce_min  in  32  job start nonce (inclusive).
- nonce_max  in  32  job end nonce (inclusive); nonce_max >= nonce_min is guaranteed by the host.
- core_reset  out  NUM_CORES  one-cycle pulse per enabled core at job load.
- core_nonce_min  out  32*NUM_CORES  per-core slice start; core i in bits [32i+31:32i].
- core_nonce_max  out  32*NUM_CORES  per-core slice end.
- core_enable  out  NUM_CORES  level; high means the core owns a valid slice.
- core_done  in  NUM_CORES  level from core: its slice is exhausted.
- core_golden_valid  in  NUM_CORES  one-cycle pulse per found nonce.
- core_golden_nonce  in  32*NUM_CORES  nonce qualified by core_golden_valid.
- golden_valid  out  1  FIFO head valid.
- golden_ready  in  1  consumer accepts head when golden_valid && golden_ready.
- golden_nonce  out  32  FIFO head data.
- job_busy  out  1  high from new_work until all enabled cores are done.
- job_done  out  1  level, high in DONE; cleared by new_work.
- drop_count  out  DROP_W  saturating count of golden nonces lost.

Behaviour:
- Reset values: all outputs 0. State = IDLE, FIFO empty, holding registers clear.
- States:
  - IDLE: wait for new_work.
  - CALC: one cycle. Computes span = nonce_max - nonce_min + 1 (33-bit) and chunk = span >> CORES_LOG2.
  - LOAD: one cycle. Registers slices and pulses core_reset.
  - RUN: cores searching.
  - DONE: all enabled cores done.
- new_work is accepted in any state, including mid-RUN. It goes to CALC and, in the same cycle, flushes the FIFO and all holding registers (stale nonces are discarded) and drops job_done. drop_count is not cleared.
- Latency: new_work at cycle t -> core_reset/core_enable/slices valid at t+2.
- Partition when chunk != 0:
  - core i min = nonce_min + i*chunk.
  - core i max = min + chunk - 1.
  - Last core max = nonce_max, so it absorbs the remainder.
  - All cores enabled.
- Partition when chunk == 0 (span < NUM_CORES): core 0 gets [nonce_min, nonce_max]; other cores are disabled with slices 0.
- Full range (min=0, max=FFFFFFFF): span = 2^32 is held in 33 bits; no overflow.
- RUN -> DONE when (core_done | ~core_enable) is all ones. core_done is ignored for the two cycles after core_reset.
- Golden capture:
  - A core_golden_valid pulse is ignored in CALC and LOAD, and on disabled cores.
  - Otherwise the nonce goes into that core's holding register and its pending bit is set.
  - If pending is already set on a new pulse, the new nonce is dropped and drop_count increments (saturates at all ones).
- Arbiter: each cycle, if the FIFO is not full, push one pending core chosen round-robin, starting after the last granted index, and clear its pending bit. If the FIFO is full, holding registers wait; no drop occurs unless a holding register is overwritten.
- Same cycle, same core: a pulse arriving while that core is being granted is captured, not counted as a drop.
- FIFO:
  - Registered output; push-to-golden_valid latency is 1 cycle.
  - Simultaneous push and pop are allowed when full (the pop frees the slot in the same cycle).
  - Pop on empty is a no-op.
- Golden nonces are still accepted in DONE, since a core may report on its final nonce.

Decomposition:
- Shared package miner_pkg: DISPATCH_IDLE/CALC/LOAD/RUN/DONE state encodings and the NONCE_W=32 constant.
- One sub-module, golden_fifo: synchronous FIFO parameterised by width and depth, with flush input and full/empty flags.
- The top-level successor wires miner_dispatch to NUM_CORES fpgaminer_top instances and uart_comm.

Test Plan:
- CORES_LOG2=2, new_work min=0x1000 max=0x13FF at t -> at t+2 core_reset=4'b1111; slices 0x1000-10FF, 0x1100-11FF, 0x1200-12FF, 0x1300-13FF; job_busy=1.
- min=0x10 max=0x12 (span 3 < 4) -> core_enable=4'b0001, core0 slice 0x10-0x12; core_done[0]=1 -> job_done=1 two cycles later.
- min=0 max=FFFFFFFF -> chunk=0x40000000; core3 max=FFFFFFFF. min=0 max=0x0A -> core3 slice 0x06-0x0A (remainder).
- Cores 0..3 pulse golden in the same cycle with nonces A0..A3, golden_ready=1 -> FIFO outputs A0,A1,A2,A3 in order, one per cycle; drop_count=0.
- golden_ready=0, 10 pulses from core1 -> FIFO holds first 8, holding register holds 9th, 10th dropped (drop_count=1). Raise ready -> 9 nonces emerge.
- Mid-RUN new_work with FIFO holding 3 nonces -> golden_valid=0 next cycle, job_done=0, new slices loaded at t+2. reset asserted mid-RUN -> all outputs 0 next cycle.
